// File: rtl/pwm_capture.sv
// PWM input capture.
// Measures period and high time of an asynchronous pulse train in clk cycles.
// Results are published as a coherent pair with a one-cycle valid strobe.
// A sticky timeout flag is raised when the counter saturates without an edge.
module pwm_capture #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] period_o,
  output logic [WIDTH-1:0] high_o,
  output logic             valid_o,
  output logic             timeout_o,
  output logic             level_o
);

  localparam logic [WIDTH-1:0] CntMax    = {WIDTH{1'b1}};
  // One below saturation: cnt+1 would reach 2^WIDTH-1, which is not reportable.
  localparam logic [WIDTH-1:0] SatThresh = {{(WIDTH-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    StWaitRise,
    StHigh,
    StLow,
    StTimeout
  } state_e;

  state_e state_q, state_d;

  logic             sync1_q, sync2_q, sync3_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] high_shadow_q;
  logic             discard_q;

  logic             rise_det, fall_det;
  logic             sat;
  logic [WIDTH-1:0] cnt_plus1;
  logic [WIDTH-1:0] cnt_sat_inc;

  // FSM control strobes
  logic cnt_clr;
  logic cnt_inc;
  logic high_latch;
  logic period_done;
  logic enter_timeout;
  logic report;

  assign rise_det    = sync2_q & ~sync3_q;
  assign fall_det    = ~sync2_q & sync3_q;
  assign level_o     = sync2_q;
  assign cnt_plus1   = cnt_q + 1'b1;
  assign cnt_sat_inc = (cnt_q == CntMax) ? cnt_q : cnt_plus1;
  assign sat         = (cnt_q >= SatThresh);
  assign report      = period_done & ~discard_q;

  // Two-flop synchronizer plus a third flop for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= pwm_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StWaitRise;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control decode; saturation wins over a coincident edge.
  always_comb begin
    state_d       = state_q;
    cnt_clr       = 1'b0;
    cnt_inc       = 1'b0;
    high_latch    = 1'b0;
    period_done   = 1'b0;
    enter_timeout = 1'b0;
    unique case (state_q)
      StWaitRise: begin
        if (rise_det) begin
          cnt_clr = 1'b1;
          state_d = StHigh;
        end
      end
      StHigh: begin
        if (sat) begin
          state_d = StTimeout;
        end else begin
          cnt_inc = 1'b1;
          if (fall_det) begin
            high_latch = 1'b1;
            state_d    = StLow;
          end
        end
      end
      StLow: begin
        if (sat) begin
          state_d = StTimeout;
        end else if (rise_det) begin
          period_done = 1'b1;
          cnt_clr     = 1'b1;
          state_d     = StHigh;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      StTimeout: begin
        enter_timeout = 1'b1;
        state_d       = StWaitRise;
      end
      default: state_d = StWaitRise;
    endcase
  end

  // Cycle counter: cleared on a rising edge, counts while measuring.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (cnt_inc) begin
      cnt_q <= cnt_sat_inc;
    end
  end

  // High time is held in a shadow so period/high publish as one pair.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      high_shadow_q <= '0;
    end else if (high_latch) begin
      high_shadow_q <= cnt_plus1;
    end
  end

  // Discard flag: first full period after reset or timeout is untrusted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      discard_q <= 1'b1;
    end else if (enter_timeout) begin
      discard_q <= 1'b1;
    end else if (period_done) begin
      discard_q <= 1'b0;
    end
  end

  // Result registers, valid strobe and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      period_o  <= '0;
      high_o    <= '0;
      valid_o   <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      valid_o <= report;
      if (report) begin
        period_o  <= cnt_plus1;
        high_o    <= high_shadow_q;
        timeout_o <= 1'b0;
      end else if (enter_timeout) begin
        timeout_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Testbench for pwm_capture (WIDTH=8 so saturation is reachable quickly).
// The reference model works on the driven waveform: it records rising/falling
// edge times and derives period/high by subtraction, with fixed pipeline
// latencies for when each result becomes visible.
module tb_pwm_capture;

  localparam int unsigned W       = 8;
  localparam int          SatSpan = (1 << W) - 1;
  localparam int          TMax    = 16384;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         pwm_in;
  logic [W-1:0] period_o;
  logic [W-1:0] high_o;
  logic         valid_o;
  logic         timeout_o;
  logic         level_o;

  pwm_capture #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pwm_in    (pwm_in),
    .period_o  (period_o),
    .high_o    (high_o),
    .valid_o   (valid_o),
    .timeout_o (timeout_o),
    .level_o   (level_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int t        = 0;

  // Scheduled expectations, indexed by sample step.
  bit ev_rep [TMax];
  int ev_per [TMax];
  int ev_hi  [TMax];
  bit ev_to  [TMax];
  bit ev_rst [TMax];
  bit lev_q  [TMax];

  logic [W-1:0] exp_period  = '0;
  logic [W-1:0] exp_high    = '0;
  logic         exp_valid   = 1'b0;
  logic         exp_timeout = 1'b0;
  logic         exp_level   = 1'b0;

  // Model state in input time.
  bit prev_in   = 1'b0;
  bit armed     = 1'b0;
  bit discard   = 1'b1;
  int t_rise    = 0;
  int t_fall    = 0;
  int ign_until = -1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic model(input bit v, input bit rst);
    if (rst) begin
      for (int i = 1; i <= 6; i++) begin
        ev_rep[t+i] = 1'b0;
        ev_to[t+i]  = 1'b0;
      end
      ev_rst[t+1] = 1'b1;
      lev_q[t+1]  = 1'b0;
      lev_q[t+2]  = 1'b0;
      prev_in     = 1'b0;
      armed       = 1'b0;
      discard     = 1'b1;
      ign_until   = -1;
      return;
    end
    lev_q[t+2] = v;
    if (armed && (t - t_rise >= SatSpan)) begin
      armed     = 1'b0;
      discard   = 1'b1;
      ev_to[t+4] = 1'b1;
      ign_until = t + 1;
    end
    if (t > ign_until) begin
      if (v && !prev_in) begin
        if (armed) begin
          if (!discard) begin
            ev_rep[t+3] = 1'b1;
            ev_per[t+3] = t - t_rise;
            ev_hi[t+3]  = t_fall - t_rise;
          end
          discard = 1'b0;
        end
        armed  = 1'b1;
        t_rise = t;
      end else if (!v && prev_in && armed) begin
        t_fall = t;
      end
    end
    prev_in = v;
  endtask

  // One clock: compare outputs at the falling edge, then drive the next input.
  task automatic step(input bit v, input bit rst);
    @(negedge clk);
    if (t + 8 >= TMax) begin
      $display("FAIL step_budget step=%0d exceeded=%0d", t, TMax);
      $fatal(1, "step budget exhausted");
    end
    if (ev_rst[t]) begin
      exp_period  = '0;
      exp_high    = '0;
      exp_timeout = 1'b0;
    end
    if (ev_to[t]) exp_timeout = 1'b1;
    exp_valid = ev_rep[t];
    if (ev_rep[t]) begin
      exp_period  = W'(ev_per[t]);
      exp_high    = W'(ev_hi[t]);
      exp_timeout = 1'b0;
    end
    exp_level = lev_q[t];
    chk("valid",   16'(valid_o),   16'(exp_valid));
    chk("period",  16'(period_o),  16'(exp_period));
    chk("high",    16'(high_o),    16'(exp_high));
    chk("timeout", 16'(timeout_o), 16'(exp_timeout));
    chk("level",   16'(level_o),   16'(exp_level));
    rst_n  = ~rst;
    pwm_in = v;
    model(v, rst);
    t++;
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    for (int p = 0; p < n; p++) begin
      repeat (hi) step(1'b1, 1'b0);
      repeat (lo) step(1'b0, 1'b0);
    end
  endtask

  int cmp, hi, lo, reps, nvalid, nto;

  // Independent tally of strobes for coarse sanity counts.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && valid_o === 1'b1) nvalid++;
    if (timeout_o === 1'b1) nto++;
  end

  initial begin
    nvalid = 0;
    nto    = 0;
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    repeat (2) @(posedge clk);
    repeat (3) step(1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0);

    // 4 high / 6 low: first report after the third rise, then 10/4 every period.
    wave(4, 6, 6);
    chk("valid_count_4_6", 16'(nvalid), 16'd4);

    // Generator loop-back, Top=9: high while counter < compare.
    for (int k = 0; k < 4; k++) begin
      cmp = int'($urandom_range(1, 9));
      for (int p = 0; p < 4; p++)
        for (int c = 0; c <= 9; c++) step(c < cmp, 1'b0);
    end
    chk("no_timeout_loopback", 16'(nto), 16'd0);

    // 20/10 square then idle low: timeout, results hold, then resume.
    wave(10, 10, 4);
    repeat (300) step(1'b0, 1'b0);
    chk("timeout_seen", 16'(timeout_o), 16'd1);
    chk("period_hold", 16'(period_o), 16'd20);
    chk("high_hold", 16'(high_o), 16'd10);
    wave(10, 10, 4);
    chk("timeout_cleared", 16'(timeout_o), 16'd0);

    // Fastest input: toggle every cycle.
    wave(1, 1, 12);

    // Switch 10/4 to 16/12 on a period boundary.
    wave(4, 6, 3);
    wave(12, 4, 3);

    // Reset for one cycle in the middle of a high phase.
    repeat (2) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    repeat (2) step(1'b1, 1'b0);
    repeat (6) step(1'b0, 1'b0);
    wave(4, 6, 4);

    // Largest reportable period, then one that must time out.
    wave(100, SatSpan - 1 - 100, 3);
    wave(100, SatSpan - 100, 3);
    wave(3, 5, 4);

    // Random pulse trains.
    for (int k = 0; k < 15; k++) begin
      hi   = int'($urandom_range(1, 30));
      lo   = int'($urandom_range(1, 30));
      reps = int'($urandom_range(3, 6));
      wave(hi, lo, reps);
    end
    repeat (10) step(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
